hdmi_vtg_pattern: RTL and testbench

Parametrised video timing generator with a selectable test-pattern source, driving the IOB output registers of the HDMI ADV7511 transmitter port in the sys2 (SI570) pixel-clock domain. It generalises the fixed 1080p60 timing and ramp/box patterns to any raster, selectable sync polarity and 16/24-bit output width. It adds an enable, frame-aligned mode switching, colour bars, and a start-of-frame strobe.

---
 rtl/hdmi_vtg_pattern_if.sv | 30 +++
 rtl/hdmi_vtg_pattern.sv | 209 ++++++++++++++++++++
 tb/tb_hdmi_vtg_pattern.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_vtg_pattern_if.sv
// Video port bundle for hdmi_vtg_pattern.
//   en, mode      : control into the generator (raster enable, pattern select)
//   vid_de/hs/vs  : timing strobes out of the generator
//   vid_data      : pixel word, DW bits
//   vid_sof       : start-of-frame pulse, aligned with pixel (0,0)
//   fcnt          : frame counter, aligned with the displayed pixel
interface hdmi_vtg_pattern_if #(
    parameter int unsigned DW = 16
);
    logic          en;
    logic [3:0]    mode;
    logic          vid_de;
    logic          vid_hs;
    logic          vid_vs;
    logic [DW-1:0] vid_data;
    logic          vid_sof;
    logic [11:0]   fcnt;

    // generator side
    modport master (
        input  en, mode,
        output vid_de, vid_hs, vid_vs, vid_data, vid_sof, fcnt
    );

    // consumer / controller side
    modport slave (
        output en, mode,
        input  vid_de, vid_hs, vid_vs, vid_data, vid_sof, fcnt
    );
endinterface

// File: rtl/hdmi_vtg_pattern.sv
// Parametrised video timing generator with test-pattern source for the
// ADV7511 HDMI transmitter port, sys2 pixel-clock domain.
//   sys2_clk : pixel clock
//   sys2_rst : synchronous active-high reset
//   vif      : master side of hdmi_vtg_pattern_if (en/mode in, video out)
// Pipeline: stage 0 counters + mode_r, stage 1 decode, stage 2 output flops.
// Outputs therefore show the counter state from two edges earlier.
module hdmi_vtg_pattern #(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned H_FP     = 88,
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_BP     = 148,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned V_FP     = 4,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 36,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned DW       = 16,
    parameter int unsigned BOX_X    = 128,
    parameter int unsigned BOX_Y    = 128,
    parameter int unsigned BOX_SZ   = 128
) (
    input  logic                sys2_clk,
    input  logic                sys2_rst,
    hdmi_vtg_pattern_if.master  vif
);

    localparam int unsigned H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // counters are at least 11 bits so the widest ramp slice [10:3] exists
    localparam int unsigned H_CLOG = $clog2(H_TOT);
    localparam int unsigned V_CLOG = $clog2(V_TOT);
    localparam int unsigned HCW    = (H_CLOG > 11) ? H_CLOG : 11;
    localparam int unsigned VCW    = (V_CLOG > 11) ? V_CLOG : 11;
    localparam int unsigned BAR_W  = H_ACTIVE / 8;
    localparam int unsigned BAR_CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int unsigned NCH    = (DW - 8) / 8;

    localparam logic [HCW-1:0] H_ACT_C  = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] H_LAST_C = HCW'(H_TOT - 1);
    localparam logic [HCW-1:0] HS_BEG_C = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] HS_END_C = HCW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HCW-1:0] BX_BEG_C = HCW'(BOX_X);
    localparam logic [HCW-1:0] BX_END_C = HCW'(BOX_X + BOX_SZ - 1);
    localparam logic [VCW-1:0] V_ACT_C  = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] V_LAST_C = VCW'(V_TOT - 1);
    localparam logic [VCW-1:0] VS_BEG_C = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] VS_END_C = VCW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VCW-1:0] BY_BEG_C = VCW'(BOX_Y);
    localparam logic [VCW-1:0] BY_END_C = VCW'(BOX_Y + BOX_SZ - 1);
    localparam logic [BAR_CW-1:0] BAR_LAST_C = BAR_CW'(BAR_W - 1);
    localparam logic [DW-9:0]  CHROMA   = {NCH{8'h80}};
    localparam logic           HS_IDLE  = ~HS_POL;
    localparam logic           VS_IDLE  = ~VS_POL;

    // ---------------- stage 0: raster counters ----------------
    logic [HCW-1:0]    hcnt;
    logic [VCW-1:0]    vcnt;
    logic [11:0]       fcnt;
    logic [3:0]        mode_r;
    logic [2:0]        bar;
    logic [BAR_CW-1:0] bar_sub;

    logic h_wrap_c;
    logic v_wrap_c;
    logic at_origin_c;

    assign h_wrap_c    = (hcnt == H_LAST_C);
    assign v_wrap_c    = (vcnt == V_LAST_C);
    assign at_origin_c = (hcnt == '0) && (vcnt == '0);

    // Counters; bar/bar_sub form a divider-free column counter that restarts each line.
    always_ff @(posedge sys2_clk) begin
        if (sys2_rst) begin
            hcnt    <= '0;
            vcnt    <= '0;
            fcnt    <= '0;
            mode_r  <= '0;
            bar     <= '0;
            bar_sub <= '0;
        end else if (!vif.en) begin
            hcnt    <= '0;
            vcnt    <= '0;
            bar     <= '0;
            bar_sub <= '0;
        end else begin
            if (at_origin_c) begin
                mode_r <= vif.mode;
            end
            if (h_wrap_c) begin
                hcnt    <= '0;
                bar     <= '0;
                bar_sub <= '0;
                if (v_wrap_c) begin
                    vcnt <= '0;
                    fcnt <= fcnt + 12'd1;
                end else begin
                    vcnt <= vcnt + VCW'(1);
                end
            end else begin
                hcnt <= hcnt + HCW'(1);
                if (bar_sub == BAR_LAST_C) begin
                    bar_sub <= '0;
                    bar     <= bar + 3'd1;
                end else begin
                    bar_sub <= bar_sub + BAR_CW'(1);
                end
            end
        end
    end

    // ---------------- stage 1: decode ----------------
    // At (0,0) mode_r is being loaded on this same edge, so the live input
    // is used for that pixel to keep the whole frame on one mode.
    logic [3:0] mode_sel_c;
    logic       box_c;
    logic       de_c;
    logic       hs_c;
    logic       vs_c;
    logic [7:0] luma_c;

    assign mode_sel_c = at_origin_c ? vif.mode : mode_r;
    assign box_c      = (hcnt >= BX_BEG_C) && (hcnt <= BX_END_C) &&
                        (vcnt >= BY_BEG_C) && (vcnt <= BY_END_C);
    assign de_c       = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
    assign hs_c       = (hcnt >= HS_BEG_C) && (hcnt <= HS_END_C);
    assign vs_c       = (vcnt >= VS_BEG_C) && (vcnt <= VS_END_C);

    // Luma per pattern mode.
    always_comb begin
        luma_c = 8'h00;
        case (mode_sel_c)
            4'h0:    luma_c = hcnt[7:0];
            4'h1:    luma_c = vcnt[7:0];
            4'h2:    luma_c = hcnt[8:1];
            4'h3:    luma_c = vcnt[8:1];
            4'h4:    luma_c = hcnt[9:2];
            4'h5:    luma_c = vcnt[9:2];
            4'h6:    luma_c = hcnt[10:3];
            4'h7:    luma_c = vcnt[10:3];
            4'h8:    luma_c = box_c ? vcnt[7:0] : hcnt[7:0];
            4'h9:    luma_c = box_c ? fcnt[7:0] : hcnt[7:0];
            4'hA:    luma_c = {bar, 5'b0_0000};
            default: luma_c = 8'h00;
        endcase
    end

    logic        s1_de;
    logic        s1_hs;
    logic        s1_vs;
    logic        s1_sof;
    logic [7:0]  s1_luma;
    logic [11:0] s1_fcnt;

    // Decode register; idle while stopped, frame count keeps tracking.
    always_ff @(posedge sys2_clk) begin
        if (sys2_rst || !vif.en) begin
            s1_de   <= 1'b0;
            s1_hs   <= HS_IDLE;
            s1_vs   <= VS_IDLE;
            s1_sof  <= 1'b0;
            s1_luma <= 8'h00;
            s1_fcnt <= sys2_rst ? 12'd0 : fcnt;
        end else begin
            s1_de   <= de_c;
            s1_hs   <= hs_c ? HS_POL : HS_IDLE;
            s1_vs   <= vs_c ? VS_POL : VS_IDLE;
            s1_sof  <= at_origin_c;
            s1_luma <= luma_c;
            s1_fcnt <= fcnt;
        end
    end

    // ---------------- stage 2: output flops ----------------
    (* IOB = "TRUE" *) logic          vid_de_q;
    (* IOB = "TRUE" *) logic          vid_hs_q;
    (* IOB = "TRUE" *) logic          vid_vs_q;
    (* IOB = "TRUE" *) logic [DW-1:0] vid_data_q;
    (* IOB = "TRUE" *) logic          vid_sof_q;
    logic [11:0] fcnt_q;

    // Pad-side registers; data is blanked outside the active area.
    always_ff @(posedge sys2_clk) begin
        if (sys2_rst || !vif.en) begin
            vid_de_q   <= 1'b0;
            vid_hs_q   <= HS_IDLE;
            vid_vs_q   <= VS_IDLE;
            vid_data_q <= '0;
            vid_sof_q  <= 1'b0;
            fcnt_q     <= sys2_rst ? 12'd0 : s1_fcnt;
        end else begin
            vid_de_q   <= s1_de;
            vid_hs_q   <= s1_hs;
            vid_vs_q   <= s1_vs;
            vid_data_q <= s1_de ? {CHROMA, s1_luma} : '0;
            vid_sof_q  <= s1_sof;
            fcnt_q     <= s1_fcnt;
        end
    end

    assign vif.vid_de   = vid_de_q;
    assign vif.vid_hs   = vid_hs_q;
    assign vif.vid_vs   = vid_vs_q;
    assign vif.vid_data = vid_data_q;
    assign vif.vid_sof  = vid_sof_q;
    assign vif.fcnt     = fcnt_q;

endmodule

// File: tb/tb_hdmi_vtg_pattern.sv
// Bench for hdmi_vtg_pattern on a 24x12 raster (H 16/2/3/3, V 8/1/2/1,
// box 4..7 x 4..7). DUT a: DW=16, positive syncs. DUT b: DW=24, negative syncs.
module tb_hdmi_vtg_pattern;

    logic sys2_clk;
    logic rst_a;
    logic rst_b;
    int   n_cmp;
    int   n_err;

    hdmi_vtg_pattern_if #(.DW(16)) vif_a ();
    hdmi_vtg_pattern_if #(.DW(24)) vif_b ();

    hdmi_vtg_pattern #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .DW(16),
        .BOX_X(4), .BOX_Y(4), .BOX_SZ(4)
    ) dut_a (
        .sys2_clk(sys2_clk),
        .sys2_rst(rst_a),
        .vif     (vif_a)
    );

    hdmi_vtg_pattern #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .DW(24),
        .BOX_X(4), .BOX_Y(4), .BOX_SZ(4)
    ) dut_b (
        .sys2_clk(sys2_clk),
        .sys2_rst(rst_b),
        .vif     (vif_b)
    );

    initial sys2_clk = 1'b0;
    always #5 sys2_clk = ~sys2_clk;

    typedef struct {
        logic [3:0] mode;
        int         frame;
        int         line;
        int         pix;
        logic       de;
        logic       hs;
        logic       vs;
        logic       sof;
        logic [7:0] luma;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int m, input int f, input int l, input int x,
                       input int de, input int hs, input int vs, input int sof,
                       input int lu);
        vec_t v;
        v.mode  = 4'(m);
        v.frame = f;
        v.line  = l;
        v.pix   = x;
        v.de    = (de != 0);
        v.hs    = (hs != 0);
        v.vs    = (vs != 0);
        v.sof   = (sof != 0);
        v.luma  = 8'(lu);
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys2_clk);
        #1;
    endtask

    // Checks every output of DUT a; data expected as {8'h80, luma} when de.
    task automatic check_a(input string tag, input int de, input int hs,
                           input int vs, input int sof, input int lu, input int f);
        chk({tag, " de"},   32'(vif_a.vid_de),   de);
        chk({tag, " hs"},   32'(vif_a.vid_hs),   hs);
        chk({tag, " vs"},   32'(vif_a.vid_vs),   vs);
        chk({tag, " sof"},  32'(vif_a.vid_sof),  sof);
        chk({tag, " data"}, 32'(vif_a.vid_data), (de != 0) ? (32'h8000 | lu) : 0);
        chk({tag, " fcnt"}, 32'(vif_a.fcnt),     f);
    endtask

    task automatic reset_a(input int m);
        vif_a.en   = 1'b1;
        vif_a.mode = 4'(m);
        rst_a      = 1'b1;
        step(2);
        rst_a      = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        vif_a.en = 1'b1;  vif_a.mode = 4'd0;
        vif_b.en = 1'b1;  vif_b.mode = 4'd0;

        // mode, frame, line, pix, de, hs, vs, sof, luma
        add(0, 0, 0,  0, 1, 0, 0, 1, 0);
        add(0, 0, 0,  1, 1, 0, 0, 0, 1);
        add(0, 0, 0, 15, 1, 0, 0, 0, 15);
        add(0, 0, 0, 16, 0, 0, 0, 0, 0);
        add(0, 0, 0, 17, 0, 0, 0, 0, 0);
        add(0, 0, 0, 18, 0, 1, 0, 0, 0);
        add(0, 0, 0, 20, 0, 1, 0, 0, 0);
        add(0, 0, 0, 21, 0, 0, 0, 0, 0);
        add(0, 0, 0, 23, 0, 0, 0, 0, 0);
        add(0, 0, 2,  7, 1, 0, 0, 0, 7);
        add(0, 0, 7, 15, 1, 0, 0, 0, 15);
        add(0, 0, 8,  3, 0, 0, 0, 0, 0);
        add(0, 0, 8, 23, 0, 0, 0, 0, 0);
        add(0, 0, 9,  0, 0, 0, 1, 0, 0);
        add(0, 0, 9, 19, 0, 1, 1, 0, 0);
        add(0, 0, 10,23, 0, 0, 1, 0, 0);
        add(0, 0, 11, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0,  0, 1, 0, 0, 1, 0);
        add(1, 0, 5,  3, 1, 0, 0, 0, 5);
        add(1, 1, 7, 15, 1, 0, 0, 0, 7);
        add(2, 0, 0,  9, 1, 0, 0, 0, 4);
        add(3, 0, 7,  2, 1, 0, 0, 0, 3);
        add(4, 0, 0, 13, 1, 0, 0, 0, 3);
        add(5, 0, 7,  4, 1, 0, 0, 0, 1);
        add(6, 0, 0, 15, 1, 0, 0, 0, 1);
        add(7, 0, 7,  8, 1, 0, 0, 0, 0);
        add(8, 0, 5,  6, 1, 0, 0, 0, 5);
        add(8, 0, 5,  8, 1, 0, 0, 0, 8);
        add(8, 0, 3,  5, 1, 0, 0, 0, 5);
        add(8, 0, 4,  3, 1, 0, 0, 0, 3);
        add(9, 0, 4,  4, 1, 0, 0, 0, 0);
        add(9, 0, 7,  7, 1, 0, 0, 0, 0);
        add(9, 0, 4,  3, 1, 0, 0, 0, 3);
        add(9, 0, 4,  8, 1, 0, 0, 0, 8);
        add(9, 1, 4,  4, 1, 0, 0, 0, 1);
        add(9, 1, 7,  7, 1, 0, 0, 0, 1);
        add(9, 1, 6,  5, 1, 0, 0, 0, 1);
        add(9, 1, 3,  5, 1, 0, 0, 0, 5);
        add(9, 1, 5,  8, 1, 0, 0, 0, 8);
        add(10, 0, 0, 0, 1, 0, 0, 1, 0);
        add(10, 0, 0, 1, 1, 0, 0, 0, 0);
        add(10, 0, 0, 2, 1, 0, 0, 0, 32);
        add(10, 0, 0, 3, 1, 0, 0, 0, 32);
        add(10, 0, 0,14, 1, 0, 0, 0, 224);
        add(10, 0, 0,15, 1, 0, 0, 0, 224);
        add(10, 0, 1, 0, 1, 0, 0, 0, 0);
        add(10, 0, 3, 9, 1, 0, 0, 0, 128);
        add(10, 0, 5, 7, 1, 0, 0, 0, 96);
        add(10, 0, 9, 5, 0, 0, 1, 0, 0);
        add(11, 0, 2, 5, 1, 0, 0, 0, 0);
        add(15, 0, 0, 0, 1, 0, 0, 1, 0);

        // reset state
        step(2);
        check_a("reset", 0, 0, 0, 0, 0, 0);

        // table: fresh reset per vector, pixel p visible p+2 edges after release
        foreach (vq[i]) begin
            reset_a(int'(vq[i].mode));
            step(2 + vq[i].frame * 288 + vq[i].line * 24 + vq[i].pix);
            check_a($sformatf("vec%0d m%0d f%0d y%0d x%0d", i, vq[i].mode,
                              vq[i].frame, vq[i].line, vq[i].pix),
                    int'(vq[i].de), int'(vq[i].hs), int'(vq[i].vs),
                    int'(vq[i].sof), int'(vq[i].luma), vq[i].frame);
        end

        // three frames: vsync lines, blanking, sof period, fcnt sequence
        begin
            int vs_hi, vs_bad, de_bad, sof_cnt, sof_bad;
            vs_hi = 0; vs_bad = 0; de_bad = 0; sof_cnt = 0; sof_bad = 0;
            reset_a(0);
            for (int p = -1; p < 864; p++) begin
                int ln;
                step(1);
                if (p < 0) continue;
                ln = (p % 288) / 24;
                if (vif_a.vid_vs) vs_hi++;
                if (vif_a.vid_vs != (ln == 9 || ln == 10)) vs_bad++;
                if (vif_a.vid_de && ln >= 8) de_bad++;
                if (vif_a.vid_sof) begin
                    sof_cnt++;
                    if ((p % 288) != 0) sof_bad++;
                    chk($sformatf("fcnt at sof p=%0d", p), 32'(vif_a.fcnt), p / 288);
                end
            end
            chk("vs high cycles", vs_hi, 144);
            chk("vs wrong line", vs_bad, 0);
            chk("de in vblank", de_bad, 0);
            chk("sof count", sof_cnt, 3);
            chk("sof off period", sof_bad, 0);
        end

        // mid-frame mode change 0->1 only takes effect next frame
        begin
            int cur;
            reset_a(0);
            step(2 + 72);
            vif_a.mode = 4'd1;
            step(58);
            check_a("mode hold f0 y5 x10", 1, 0, 0, 0, 10, 0);
            cur = 130;
            for (int n = 0; n < 8; n++) begin
                step(288 + n * 24 + 2 - cur);
                cur = 288 + n * 24 + 2;
                check_a($sformatf("mode new f1 y%0d", n), 1, 0, 0, 0, n, 1);
            end
        end

        // en low at pixel (5,3) of frame 1, then restart
        reset_a(0);
        step(2 + 288 + 72 + 5);
        check_a("pre-stop x5 y3", 1, 0, 0, 0, 5, 1);
        vif_a.en = 1'b0;
        step(1);
        check_a("stopped 1", 0, 0, 0, 0, 0, 1);
        step(4);
        check_a("stopped 5", 0, 0, 0, 0, 0, 1);
        vif_a.en = 1'b1;
        step(1);
        check_a("restart +1", 0, 0, 0, 0, 0, 1);
        step(1);
        check_a("restart +2", 1, 0, 0, 1, 0, 1);
        step(3);
        check_a("restart x3", 1, 0, 0, 0, 3, 1);
        rst_a = 1'b1;
        step(1);
        check_a("mid-line reset a", 0, 0, 0, 0, 0, 0);
        rst_a = 1'b0;

        // DUT b: 24-bit data, active-low syncs
        step(1);
        chk("b reset hs", 32'(vif_b.vid_hs), 1);
        chk("b reset vs", 32'(vif_b.vid_vs), 1);
        chk("b reset data", 32'(vif_b.vid_data), 0);
        rst_b = 1'b0;
        step(2);
        chk("b sof", 32'(vif_b.vid_sof), 1);
        chk("b data x0", 32'(vif_b.vid_data), 32'h808000);
        step(5);
        chk("b data x5", 32'(vif_b.vid_data), 32'h808005);
        step(12);
        chk("b hs x17", 32'(vif_b.vid_hs), 1);
        chk("b data x17", 32'(vif_b.vid_data), 0);
        step(1);
        chk("b hs x18", 32'(vif_b.vid_hs), 0);
        step(13);
        chk("b data y1 x7", 32'(vif_b.vid_data), 32'h808007);
        rst_b = 1'b1;
        step(1);
        chk("b rst de", 32'(vif_b.vid_de), 0);
        chk("b rst hs", 32'(vif_b.vid_hs), 1);
        chk("b rst vs", 32'(vif_b.vid_vs), 1);
        chk("b rst data", 32'(vif_b.vid_data), 0);
        chk("b rst sof", 32'(vif_b.vid_sof), 0);
        step(1);
        rst_b = 1'b0;
        step(1);
        chk("b release +1 sof", 32'(vif_b.vid_sof), 0);
        step(1);
        chk("b release +2 sof", 32'(vif_b.vid_sof), 1);
        chk("b release +2 data", 32'(vif_b.vid_data), 32'h808000);
        step(219);
        chk("b vs y9", 32'(vif_b.vid_vs), 0);
        chk("b de y9", 32'(vif_b.vid_de), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
